// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Bounds for the slice helper: WIDTH <= MAX_W and N_CH*WIDTH <= MAX_BUS.
  localparam int MAX_W   = 64;
  localparam int MAX_BUS = 16 * MAX_W;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_BUS-1:0] bus,
                                                input int idx,
                                                input int width);
    return MAX_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr with wrap, and moves the pointer
// just past the winner whenever a transfer on the granted channel happens.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int  N_CH = 4,
  localparam int CH_W = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);

  logic [CH_W-1:0] rr_ptr_q;
  logic [CH_W-1:0] rr_ptr_d;
  logic [N_CH-1:0] grant_s;
  logic [CH_W-1:0] grant_idx_s;
  logic            found_s;
  logic [CH_W:0]   cand_s;
  logic [CH_W-1:0] cand_idx_s;

  // First requesting channel at or after rr_ptr, modulo N_CH.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    cand_s      = '0;
    cand_idx_s  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (cand_s >= (CH_W+1)'(N_CH)) begin
        cand_s = cand_s - (CH_W+1)'(N_CH);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[CH_W-1:0];
      if (!found_s && req[cand_idx_s]) begin
        found_s             = 1'b1;
        grant_s[cand_idx_s] = 1'b1;
        grant_idx_s         = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves only on a real transfer, so stalls and idle cycles keep it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && found_s) begin
      if (grant_idx_s == CH_W'(N_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + CH_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = grant_idx_s;

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream multiplexer with one output register stage; channel
// choice is either an external select or round-robin over valid channels.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  parameter int  MODE  = MODE_SEL,
  localparam int CH_W  = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [CH_W-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N_CH-1:0]  grant_s;
  logic [CH_W-1:0]  grant_idx_s;
  logic             free_s;
  logic             take_s;

  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic [CH_W-1:0]  out_ch_q;
  logic [CH_W-1:0]  out_ch_d;
  logic             out_valid_q;
  logic             out_valid_d;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic sel_unused_s;
      assign sel_unused_s = ^sel;

      rr_arbiter #(
        .N_CH (N_CH)
      ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (take_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
      );
    end else begin : g_sel
      // Out-of-range select grants nothing, leaving the whole block idle.
      always_comb begin
        grant_s     = '0;
        grant_idx_s = sel;
        if (int'(sel) < N_CH) begin
          grant_s[sel] = in_valid[sel];
        end else begin
          grant_s = '0;
        end
      end
    end
  endgenerate

  // Ready is gated by reset so no producer sees a handshake while held in reset.
  assign free_s   = ~out_valid_q | out_ready;
  assign in_ready = grant_s & {N_CH{free_s & rst_n}};
  assign take_s   = |(in_valid & in_ready);

  // Output stage: load on input transfer, drop valid on a drain with no reload.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (take_s) begin
      out_valid_d = 1'b1;
      out_data_d  = WIDTH'(ch_slice(MAX_BUS'(in_data), int'(grant_idx_s), WIDTH));
      out_ch_d    = grant_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench for stream_mux_nx1: select mode (4x8), round-robin (4x8)
// and a narrow round-robin instance (3x1) exercising pointer wrap.
module tb_stream_mux_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] s_data;
  logic [3:0]  s_valid, s_ready;
  logic [1:0]  s_sel, s_och;
  logic [7:0]  s_odata;
  logic        s_ovalid, s_oready;

  logic [31:0] r_data;
  logic [3:0]  r_valid, r_ready;
  logic [1:0]  r_sel, r_och;
  logic [7:0]  r_odata;
  logic        r_ovalid, r_oready;

  logic [2:0]  w_data, w_valid, w_ready;
  logic [1:0]  w_sel, w_och;
  logic [0:0]  w_odata;
  logic        w_ovalid, w_oready;

  logic [15:0] sq[$];
  logic [15:0] rq[$];
  logic [15:0] wq[$];

  int         rr_seq [10] = '{0, 1, 2, 3, 0, 1, 3, 1, 3, 1};
  logic [2:0] w_dat  [4]  = '{3'b100, 3'b001, 3'b010, 3'b011};
  logic [2:0] w_vld  [4]  = '{3'b100, 3'b001, 3'b111, 3'b111};
  int         w_ch   [4]  = '{2, 0, 1, 2};
  int         w_bit  [4]  = '{1, 1, 1, 0};

  stream_mux_nx1 #(.N_CH(4), .WIDTH(8), .MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .sel(s_sel), .out_data(s_odata), .out_ch(s_och), .out_valid(s_ovalid), .out_ready(s_oready));

  stream_mux_nx1 #(.N_CH(4), .WIDTH(8), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(r_data), .in_valid(r_valid), .in_ready(r_ready),
    .sel(r_sel), .out_data(r_odata), .out_ch(r_och), .out_valid(r_ovalid), .out_ready(r_oready));

  stream_mux_nx1 #(.N_CH(3), .WIDTH(1), .MODE(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_data(w_data), .in_valid(w_valid), .in_ready(w_ready),
    .sel(w_sel), .out_data(w_odata), .out_ch(w_och), .out_valid(w_ovalid), .out_ready(w_oready));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic beat_cmp(input string nm, input logic [15:0] got, input bit have,
                          input logic [15:0] exp);
    n_tests++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected beat ch=%0d data='h%0h, expected none",
               nm, got[15:8], got[7:0]);
    end else if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ch=%0d data='h%0h, expected ch=%0d data='h%0h",
               nm, got[15:8], got[7:0], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic push(input int which, input int ch, input int data);
    case (which)
      0:       sq.push_back({8'(ch), 8'(data)});
      1:       rq.push_back({8'(ch), 8'(data)});
      default: wq.push_back({8'(ch), 8'(data)});
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_ovalid && s_oready) begin
        if (sq.size() > 0) beat_cmp("sel_beat", {6'b0, s_och, s_odata}, 1'b1, sq.pop_front());
        else               beat_cmp("sel_beat", {6'b0, s_och, s_odata}, 1'b0, 16'h0);
      end
      if (r_ovalid && r_oready) begin
        if (rq.size() > 0) beat_cmp("rr_beat", {6'b0, r_och, r_odata}, 1'b1, rq.pop_front());
        else               beat_cmp("rr_beat", {6'b0, r_och, r_odata}, 1'b0, 16'h0);
      end
      if (w_ovalid && w_oready) begin
        if (wq.size() > 0) beat_cmp("w1_beat", {6'b0, w_och, 7'b0, w_odata}, 1'b1, wq.pop_front());
        else               beat_cmp("w1_beat", {6'b0, w_och, 7'b0, w_odata}, 1'b0, 16'h0);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    s_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    s_valid  = 4'hF;
    s_sel    = 2'd0;
    s_oready = 1'b1;
    r_data   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    r_valid  = 4'h0;
    r_sel    = 2'd0;
    r_oready = 1'b1;
    w_data   = 3'b000;
    w_valid  = 3'b000;
    w_sel    = 2'd3;
    w_oready = 1'b1;
    tick;
    tick;

    chk("rst_out_valid", 32'(s_ovalid), 32'd0);
    chk("rst_out_data",  32'(s_odata),  32'd0);
    chk("rst_out_ch",    32'(s_och),    32'd0);
    chk("rst_in_ready",  32'(s_ready),  32'd0);
    chk("rst_rr_valid",  32'(r_ovalid), 32'd0);
    chk("rst_w1_valid",  32'(w_ovalid), 32'd0);

    // Select mode, sel stepping 0..3 with all channels valid.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_sel = 2'(i);
      #1;
      chk("sel_step_ready", 32'(s_ready), 32'd1 << i);
      if (i > 0) chk("sel_step_no_bubble", 32'(s_ovalid), 32'd1);
      push(0, i, 32'hA0 + i);
      tick;
    end
    s_valid = 4'h0;
    tick;

    // Reset in the middle of a held beat.
    s_oready = 1'b0;
    s_sel    = 2'd1;
    s_valid  = 4'hF;
    tick;
    s_valid = 4'h0;
    #1;
    chk("held_before_reset_valid", 32'(s_ovalid), 32'd1);
    chk("held_before_reset_data",  32'(s_odata),  32'hA1);
    rst_n   = 1'b0;
    s_valid = 4'hF;
    #1;
    chk("reset_drop_valid", 32'(s_ovalid), 32'd0);
    chk("reset_drop_data",  32'(s_odata),  32'd0);
    chk("reset_in_ready",   32'(s_ready),  32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_sel    = 2'd2;
    s_oready = 1'b1;
    #1;
    chk("post_reset_ready", 32'(s_ready),  32'b0100);
    chk("post_reset_idle",  32'(s_ovalid), 32'd0);
    push(0, 2, 32'hA2);
    tick;
    s_valid = 4'h0;
    #1;
    chk("post_reset_latency", 32'(s_ovalid), 32'd1);
    tick;

    // Selected channel not valid: nothing happens until it becomes valid.
    s_sel   = 2'd2;
    s_valid = 4'b1011;
    #1;
    chk("sel_invalid_ready", 32'(s_ready), 32'd0);
    tick;
    chk("sel_invalid_idle1", 32'(s_ovalid), 32'd0);
    tick;
    chk("sel_invalid_idle2", 32'(s_ovalid), 32'd0);
    chk("sel_invalid_ready2", 32'(s_ready), 32'd0);
    s_valid = 4'b1111;
    #1;
    chk("sel_valid_ready", 32'(s_ready), 32'b0100);
    push(0, 2, 32'hA2);
    tick;
    s_valid = 4'h0;
    #1;
    chk("sel_one_beat", 32'(s_ovalid), 32'd1);
    tick;
    chk("sel_drained", 32'(s_ovalid), 32'd0);

    // Round-robin: all valid, then 1010 (pointer is at 2 by then, so ch3 first).
    r_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) r_valid = 4'b1010;
      #1;
      chk("rr_ready", 32'(r_ready), 32'd1 << rr_seq[k]);
      if (k > 0) chk("rr_no_bubble", 32'(r_ovalid), 32'd1);
      push(1, rr_seq[k], 32'hB0 + rr_seq[k]);
      tick;
    end

    // Backpressure with the ch1 beat held.
    r_oready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 32'(r_ready),  32'd0);
      chk("bp_valid",    32'(r_ovalid), 32'd1);
      chk("bp_ch",       32'(r_och),    32'd1);
      chk("bp_data",     32'(r_odata),  32'hB1);
      tick;
    end
    r_oready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(r_ready), 32'b1000);
    push(1, 3, 32'hB3);
    tick;
    r_valid = 4'h0;
    tick;
    tick;

    // Three-channel, one-bit round-robin: ch2, wrap to ch0, then ch1, ch2.
    for (int k = 0; k < 4; k++) begin
      w_data  = w_dat[k];
      w_valid = w_vld[k];
      #1;
      chk("w1_ready", 32'(w_ready), 32'd1 << w_ch[k]);
      push(2, w_ch[k], w_bit[k]);
      tick;
    end
    w_valid = 3'b000;
    tick;
    tick;

    chk("sel_queue_empty", 32'(sq.size()), 32'd0);
    chk("rr_queue_empty",  32'(rq.size()), 32'd0);
    chk("w1_queue_empty",  32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
